// File: rtl/rdseq_pkg.sv
// rtl/rdseq_pkg.sv - shared state encoding, header layout and helpers for rdseq
package rdseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_HWAIT = 3'd2,
    ST_HDR   = 3'd3,
    ST_CONV  = 3'd4,
    ST_POP   = 3'd5,
    ST_GAP   = 3'd6
  } state_t;

  localparam int SMP_PER_BLK  = 8;

  localparam int HDR_W        = 12;
  localparam int HDR_BLK_LSB  = 0;
  localparam int HDR_L1AN_LSB = 4;
  localparam int HDR_LCT_BIT  = 10;
  localparam int HDR_L1AP_BIT = 11;

  function automatic logic [HDR_W-1:0] hdr_pack(input logic       l1a_ph,
                                                input logic       lct_ph,
                                                input logic [5:0] l1anum,
                                                input logic [3:0] blk);
    logic [HDR_W-1:0] h;
    h                      = '0;
    h[HDR_L1AP_BIT]        = l1a_ph;
    h[HDR_LCT_BIT]         = lct_ph;
    h[HDR_L1AN_LSB +: 6]   = l1anum;
    h[HDR_BLK_LSB +: 4]    = blk;
    return h;
  endfunction

endpackage

// File: rtl/rdseq_if.sv
// rtl/rdseq_if.sv - FIFO-head, transfer and ADC sequencing signals of rdseq
interface rdseq_if;

  logic        TEMPTY;
  logic [3:0]  BLKOUT;
  logic [7:0]  L1POUT;
  logic        SCND_BLK;
  logic        SCND_SHARED;
  logic        LCT_PH_OUT;
  logic        L1MT;
  logic [5:0]  L1ANUM;
  logic        L1A_PHASE_OUT;
  logic        XFER_BUSY;

  logic        TRGDONE;
  logic        POPL1AN;
  logic        HDR_WE;
  logic [11:0] HDR_DATA;
  logic        ADC_CONV;
  logic [3:0]  SCA_BLK;
  logic [2:0]  SCA_SMP;
  logic        SMP_L1A;
  logic        SHARED;
  logic        BUSY;
  logic [7:0]  EVT_CNT;

  modport slave (
    input  TEMPTY, BLKOUT, L1POUT, SCND_BLK, SCND_SHARED, LCT_PH_OUT,
           L1MT, L1ANUM, L1A_PHASE_OUT, XFER_BUSY,
    output TRGDONE, POPL1AN, HDR_WE, HDR_DATA, ADC_CONV, SCA_BLK, SCA_SMP,
           SMP_L1A, SHARED, BUSY, EVT_CNT
  );

  modport master (
    output TEMPTY, BLKOUT, L1POUT, SCND_BLK, SCND_SHARED, LCT_PH_OUT,
           L1MT, L1ANUM, L1A_PHASE_OUT, XFER_BUSY,
    input  TRGDONE, POPL1AN, HDR_WE, HDR_DATA, ADC_CONV, SCA_BLK, SCA_SMP,
           SMP_L1A, SHARED, BUSY, EVT_CNT
  );

endinterface

// File: rtl/rdseq_conv_tmr.sv
// rtl/rdseq_conv_tmr.sv - sample/cycle counter pair for one SCA block, optionally triplicated
module rdseq_conv_tmr
  import rdseq_pkg::*;
#(
  parameter int TMR      = 0,
  parameter int CONV_CYC = 6
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       i_en,
  output logic [2:0] o_smp,
  output logic       o_cyc_zero,
  output logic       o_done
);

  localparam int         NCP      = (TMR != 0) ? 3 : 1;
  localparam logic [3:0] CYC_LAST = 4'(CONV_CYC - 1);
  localparam logic [2:0] SMP_LAST = 3'(SMP_PER_BLK - 1);

  logic [3:0] r_cyc [NCP];
  logic [2:0] r_smp [NCP];
  logic [3:0] w_cyc;
  logic [2:0] w_smp;
  logic [3:0] w_cyc_nxt;
  logic [2:0] w_smp_nxt;

  // Every copy reloads from the voted value, so a single upset is scrubbed next cycle.
  generate
    if (NCP == 3) begin : g_vote
      assign w_cyc = (r_cyc[0] & r_cyc[1]) | (r_cyc[0] & r_cyc[2]) | (r_cyc[1] & r_cyc[2]);
      assign w_smp = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);
    end else begin : g_single
      assign w_cyc = r_cyc[0];
      assign w_smp = r_smp[0];
    end
  endgenerate

  always_comb begin
    w_cyc_nxt = '0;
    w_smp_nxt = '0;
    if (i_en) begin
      if (w_cyc == CYC_LAST) begin
        w_cyc_nxt = '0;
        w_smp_nxt = w_smp + 3'd1;
      end else begin
        w_cyc_nxt = w_cyc + 4'd1;
        w_smp_nxt = w_smp;
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCP; i++) begin
      if (!RST_N) begin
        r_cyc[i] <= '0;
        r_smp[i] <= '0;
      end else begin
        r_cyc[i] <= w_cyc_nxt;
        r_smp[i] <= w_smp_nxt;
      end
    end
  end

  assign o_smp      = w_smp;
  assign o_cyc_zero = (w_cyc == 4'd0);
  assign o_done     = i_en && (w_cyc == CYC_LAST) && (w_smp == SMP_LAST);

endmodule

// File: rtl/rdseq.sv
// rtl/rdseq.sv - block/L1A FIFO consumer sequencing 8 ADC conversions per SCA block
module rdseq
  import rdseq_pkg::*;
#(
  parameter int TMR      = 0,
  parameter int CONV_CYC = 6
) (
  input  logic   CLK,
  input  logic   RST_N,
  rdseq_if.slave bus
);

  localparam int NCP = (TMR != 0) ? 3 : 1;

  state_t     r_state [NCP];
  logic [7:0] r_evt   [NCP];
  state_t     w_state;
  state_t     w_state_nxt;
  logic [7:0] w_evt;
  logic [7:0] w_evt_nxt;

  logic [3:0] r_blk;
  logic [7:0] r_l1p;
  logic       r_shared;
  logic       r_lct;

  logic       w_in_conv;
  logic [2:0] w_smp;
  logic       w_cyc_zero;
  logic       w_conv_done;

  generate
    if (NCP == 3) begin : g_vote
      assign w_state = state_t'((r_state[0] & r_state[1]) | (r_state[0] & r_state[2]) |
                                (r_state[1] & r_state[2]));
      assign w_evt   = (r_evt[0] & r_evt[1]) | (r_evt[0] & r_evt[2]) | (r_evt[1] & r_evt[2]);
    end else begin : g_single
      assign w_state = r_state[0];
      assign w_evt   = r_evt[0];
    end
  endgenerate

  // LOAD skips HWAIT when the L1A FIFO already has an entry, giving a 3-cycle first-block latency.
  always_comb begin
    w_state_nxt = w_state;
    w_evt_nxt   = w_evt;
    case (w_state)
      ST_IDLE:  if (!bus.TEMPTY && !bus.XFER_BUSY) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (bus.SCND_BLK)  w_state_nxt = ST_CONV;
        else if (!bus.L1MT) w_state_nxt = ST_HDR;
        else               w_state_nxt = ST_HWAIT;
      end
      ST_HWAIT: if (!bus.L1MT) w_state_nxt = ST_HDR;
      ST_HDR: begin
        w_evt_nxt   = w_evt + 8'd1;
        w_state_nxt = ST_CONV;
      end
      ST_CONV:  if (w_conv_done) w_state_nxt = ST_POP;
      ST_POP:   w_state_nxt = ST_GAP;
      ST_GAP:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCP; i++) begin
      if (!RST_N) begin
        r_state[i] <= ST_IDLE;
        r_evt[i]   <= '0;
      end else begin
        r_state[i] <= w_state_nxt;
        r_evt[i]   <= w_evt_nxt;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_blk    <= '0;
      r_l1p    <= '0;
      r_shared <= 1'b0;
      r_lct    <= 1'b0;
    end else if (w_state == ST_LOAD) begin
      r_blk    <= bus.BLKOUT;
      r_l1p    <= bus.L1POUT;
      r_shared <= bus.SCND_SHARED;
      r_lct    <= bus.LCT_PH_OUT;
    end
  end

  assign w_in_conv = (w_state == ST_CONV);

  rdseq_conv_tmr #(
    .TMR      (TMR),
    .CONV_CYC (CONV_CYC)
  ) u_conv (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .i_en       (w_in_conv),
    .o_smp      (w_smp),
    .o_cyc_zero (w_cyc_zero),
    .o_done     (w_conv_done)
  );

  assign bus.TRGDONE  = (w_state == ST_POP);
  assign bus.POPL1AN  = (w_state == ST_HDR);
  assign bus.HDR_WE   = (w_state == ST_HDR);
  assign bus.HDR_DATA = (w_state == ST_HDR) ?
                        hdr_pack(bus.L1A_PHASE_OUT, r_lct, bus.L1ANUM, r_blk) : '0;
  assign bus.ADC_CONV = w_in_conv && w_cyc_zero;
  assign bus.SCA_BLK  = r_blk;
  assign bus.SCA_SMP  = w_smp;
  assign bus.SMP_L1A  = w_in_conv && r_l1p[w_smp];
  assign bus.SHARED   = r_shared;
  assign bus.BUSY     = (w_state != ST_IDLE);
  assign bus.EVT_CNT  = w_evt;

endmodule
